reg_bus_arbiter: RTL and testbench
==================================

# reg_bus_arbiter

Two-requester arbiter and sequencer for the motion system's internal 32-bit register bus (8-bit register address space, 256 registers). It shares the bus between the uP packet interface (requester 0) and an internal requester (requester 1, e.g. a status poller), running one register read or write at a time. Each transaction follows a strobe/acknowledge handshake with a timeout, so a hung or unmapped register cannot lock the bus.

## Interface
Parameters:
- TIMEOUT, 15, max cycles in WAIT_ACK before abort (1..255)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending; held stable until matching done
- req0_RW / req1_RW  in  1  1 = write, 0 = read
- req0_address / req1_address  in  8  register address
- req0_wdata / req1_wdata  in  32  write data
- req0_done / req1_done  out  1  one-cycle completion pulse
- req0_rdata / req1_rdata  out  32  read data, valid with done, held until next done to that requester
- req0_fault / req1_fault  out  1  transaction error flag, valid with done, held like rdata
- bus_strobe  out  1  one-cycle transaction start
- bus_RW  out  1  registered copy of granted RW
- bus_address  out  8  registered granted address
- bus_data_out  out  32  registered granted write data
- bus_ack  in  1  transaction complete from register file
- bus_error  in  1  qualifies bus_ack: address unmapped or write refused
- bus_data_in  in  32  read data, valid with bus_ack
- busy  out  1  high in any state other than IDLE
- grant  out  1  index of the current or last-served requester

## Operation
- States: IDLE, ISSUE, WAIT_ACK, DONE.
- IDLE: if any valid, select a requester and latch its RW, address and wdata onto the bus_* outputs and grant. Go to ISSUE.
- Arbitration is round-robin. A single valid request wins. If both are valid, the winner is the requester that is not last_grant. last_grant resets to 1, so req0 wins the first contention.
- ISSUE: bus_strobe = 1 for exactly this cycle. Clear the timeout counter. Go to WAIT_ACK. bus_ack is ignored in ISSUE.
- WAIT_ACK: the counter increments each cycle.
  - On bus_ack = 1: capture bus_data_in (reads only; writes capture 0) and fault = bus_error. Go to DONE.
  - If the counter reaches TIMEOUT with no ack: abort, rdata = 0, fault = 1, go to DONE.
  - If ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- DONE: assert reqN_done for the granted requester. Update its rdata and fault. Set last_grant = grant. Go to IDLE.
- bus_address, bus_RW and bus_data_out hold their values from ISSUE through DONE and keep them in IDLE until the next grant.
- The other requester's outputs never change during a transaction it does not own.
- Requesters deassert valid at the clock edge that ends the done cycle. The mandatory IDLE cycle after DONE ensures a served request is not re-issued.
- bus_ack outside WAIT_ACK is ignored.

## Timing
- Reset values of all outputs: 0. Internal state: state = IDLE, counter = 0, last_grant = 1.
- Reset mid-transaction: immediate return to IDLE with outputs at 0. No done is issued. A request still valid after reset release is served from scratch.
- Minimum latency, with valid high in cycle 0 (IDLE) and ack in the first WAIT_ACK cycle:
  - strobe in cycle 1
  - ack sampled in cycle 2
  - done in cycle 3
- Back-to-back throughput: at best one transaction per 4 cycles.
- Timeout: with no ack, done occurs TIMEOUT + 2 cycles after strobe (cycle TIMEOUT + 3 relative to IDLE), with fault = 1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Read: req0 reads 0x05, with bus_ack and bus_data_in = 0xDEADBEEF one cycle after strobe -> bus_address = 0x05, bus_RW = 0, a single strobe pulse, req0_done 3 cycles after valid, req0_rdata = 0xDEADBEEF, req0_fault = 0.
- Write: req1 writes 0x00000064 to 0x21 -> bus_RW = 1, bus_data_out = 0x00000064 during strobe, req1_done with rdata = 0, req0 outputs unchanged.
- Contention: req0 and req1 raised together after reset -> req0 served first, then req1. Raising both again -> req0 then req1 (alternation from last_grant = 1). req1 alone twice -> served twice.
- Timeout: TIMEOUT = 15, req0 read of 0xFF with bus_ack held low -> done 17 cycles after strobe, req0_fault = 1, req0_rdata = 0, state returns to IDLE. Ack arriving exactly on the timeout cycle -> fault = bus_error.
- Bus error: bus_ack together with bus_error = 1 on a read of 0x80 -> req0_fault = 1, data captured, busy drops after DONE.
- Reset in WAIT_ACK -> all outputs 0 asynchronously, no done pulse. After release, req0 (still valid) re-issues with a single strobe.

Source files
------------

// File: rtl/reg_bus_arbiter_if.sv
// rtl/reg_bus_arbiter_if.sv - requester and register-bus signal bundle for reg_bus_arbiter
interface reg_bus_arbiter_if;
   logic        req0_valid;
   logic        req0_RW;
   logic [7:0]  req0_address;
   logic [31:0] req0_wdata;
   logic        req0_done;
   logic [31:0] req0_rdata;
   logic        req0_fault;

   logic        req1_valid;
   logic        req1_RW;
   logic [7:0]  req1_address;
   logic [31:0] req1_wdata;
   logic        req1_done;
   logic [31:0] req1_rdata;
   logic        req1_fault;

   logic        bus_strobe;
   logic        bus_RW;
   logic [7:0]  bus_address;
   logic [31:0] bus_data_out;
   logic        bus_ack;
   logic        bus_error;
   logic [31:0] bus_data_in;

   logic        busy;
   logic        grant;

   modport slave (
      input  req0_valid, req0_RW, req0_address, req0_wdata,
      input  req1_valid, req1_RW, req1_address, req1_wdata,
      input  bus_ack, bus_error, bus_data_in,
      output req0_done, req0_rdata, req0_fault,
      output req1_done, req1_rdata, req1_fault,
      output bus_strobe, bus_RW, bus_address, bus_data_out,
      output busy, grant
   );

   modport master (
      output req0_valid, req0_RW, req0_address, req0_wdata,
      output req1_valid, req1_RW, req1_address, req1_wdata,
      output bus_ack, bus_error, bus_data_in,
      input  req0_done, req0_rdata, req0_fault,
      input  req1_done, req1_rdata, req1_fault,
      input  bus_strobe, bus_RW, bus_address, bus_data_out,
      input  busy, grant
   );
endinterface

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - round-robin two-requester arbiter and strobe/ack sequencer
// for the 32-bit register bus, aborting a transaction when the ack never comes.
module reg_bus_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   reg_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, DONE} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_q, grant_d;
   logic        busy_q, busy_d;
   logic        strobe_q, strobe_d;
   logic        rw_q, rw_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        fault0_q, fault0_d;
   logic        fault1_q, fault1_d;

   logic        pick1;
   logic        resp_en;
   logic [31:0] resp_data;
   logic        resp_fault;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      fault0_d     = fault0_q;
      fault1_d     = fault1_q;
      strobe_d     = 1'b0;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      pick1        = 1'b0;
      resp_en      = 1'b0;
      resp_data    = '0;
      resp_fault   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               // On contention the requester that was not served last wins.
               pick1    = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
               grant_d  = pick1;
               rw_d     = pick1 ? bus.req1_RW      : bus.req0_RW;
               addr_d   = pick1 ? bus.req1_address : bus.req0_address;
               wdata_d  = pick1 ? bus.req1_wdata   : bus.req0_wdata;
               strobe_d = 1'b1;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            // An ack landing on the timeout cycle still completes normally.
            if (bus.bus_ack) begin
               resp_en    = 1'b1;
               resp_data  = rw_q ? 32'd0 : bus.bus_data_in;
               resp_fault = bus.bus_error;
            end else if (cnt_q == TIMEOUT_CNT) begin
               resp_en    = 1'b1;
               resp_fault = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            last_grant_d = grant_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (resp_en) begin
         state_d = DONE;
         if (grant_q) begin
            done1_d  = 1'b1;
            rdata1_d = resp_data;
            fault1_d = resp_fault;
         end else begin
            done0_d  = 1'b1;
            rdata0_d = resp_data;
            fault0_d = resp_fault;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         busy_q       <= 1'b0;
         strobe_q     <= 1'b0;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
         fault0_q     <= 1'b0;
         fault1_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         busy_q       <= busy_d;
         strobe_q     <= strobe_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
         fault0_q     <= fault0_d;
         fault1_q     <= fault1_d;
      end
   end

   assign bus.req0_done    = done0_q;
   assign bus.req0_rdata   = rdata0_q;
   assign bus.req0_fault   = fault0_q;
   assign bus.req1_done    = done1_q;
   assign bus.req1_rdata   = rdata1_q;
   assign bus.req1_fault   = fault1_q;
   assign bus.bus_strobe   = strobe_q;
   assign bus.bus_RW       = rw_q;
   assign bus.bus_address  = addr_q;
   assign bus.bus_data_out = wdata_q;
   assign bus.busy         = busy_q;
   assign bus.grant        = grant_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - scoreboard bench for reg_bus_arbiter
module tb_reg_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reg_bus_arbiter_if bus_if ();

   reg_bus_arbiter #(.TIMEOUT(15)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   typedef struct {
      logic        rw;
      logic [7:0]  addr;
      logic [31:0] wdata;
   } strobe_t;

   typedef struct {
      int          id;
      logic [31:0] rdata;
      logic        fault;
      int          dcyc;
   } done_t;

   strobe_t exp_s[$];
   done_t   exp_d[$];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   task automatic expect_strobe(input logic rw, input logic [7:0] a, input logic [31:0] d);
      strobe_t s;
      s.rw = rw; s.addr = a; s.wdata = d;
      exp_s.push_back(s);
   endtask

   task automatic expect_done(input int id, input logic [31:0] rd, input logic f, input int dc);
      done_t e;
      e.id = id; e.rdata = rd; e.fault = f; e.dcyc = dc;
      exp_d.push_back(e);
   endtask

   task automatic raise(input int id, input logic rw, input logic [7:0] a, input logic [31:0] d);
      if (id == 0) begin
         bus_if.req0_RW = rw; bus_if.req0_address = a; bus_if.req0_wdata = d; bus_if.req0_valid = 1'b1;
      end else begin
         bus_if.req1_RW = rw; bus_if.req1_address = a; bus_if.req1_wdata = d; bus_if.req1_valid = 1'b1;
      end
   endtask

   task automatic wait_strobe();
      int n = 0;
      while (!bus_if.bus_strobe && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wait_strobe", bus_if.bus_strobe, 1);
   endtask

   // Acts as the register file: ack `delay` cycles into WAIT_ACK (negative = never),
   // then waits for done and drops the served requester's valid.
   task automatic serve(input int delay, input logic err, input logic [31:0] data);
      int n = 0;
      wait_strobe();
      if (delay >= 0) begin
         repeat (delay + 1) @(negedge clk);
         bus_if.bus_ack = 1'b1; bus_if.bus_error = err; bus_if.bus_data_in = data;
         @(negedge clk);
         bus_if.bus_ack = 1'b0; bus_if.bus_error = 1'b0; bus_if.bus_data_in = 32'hA5A5_5A5A;
      end
      while (!(bus_if.req0_done || bus_if.req1_done) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("wait_done", bus_if.req0_done | bus_if.req1_done, 1);
      if (bus_if.req0_done) bus_if.req0_valid = 1'b0;
      if (bus_if.req1_done) bus_if.req1_valid = 1'b0;
   endtask

   initial begin : monitor
      logic [31:0] m_rdata [2];
      logic        m_fault [2];
      strobe_t     last_s;
      strobe_t     s;
      done_t       e;
      logic        prev_strobe;
      int          id;
      m_rdata[0] = '0; m_rdata[1] = '0; m_fault[0] = 1'b0; m_fault[1] = 1'b0;
      prev_strobe = 1'b0;
      last_s.rw = 1'b0; last_s.addr = '0; last_s.wdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            m_rdata[0] = '0; m_rdata[1] = '0; m_fault[0] = 1'b0; m_fault[1] = 1'b0;
            prev_strobe = 1'b0;
         end else begin
            if (bus_if.bus_strobe) begin
               check("strobe_single_cycle", prev_strobe, 0);
               check("strobe_expected", exp_s.size() > 0, 1);
               if (exp_s.size() > 0) begin
                  s = exp_s.pop_front();
                  check("strobe_rw", bus_if.bus_RW, s.rw);
                  check("strobe_addr", bus_if.bus_address, s.addr);
                  check("strobe_wdata", bus_if.bus_data_out, s.wdata);
                  last_s = s;
               end
            end
            if (bus_if.req0_done || bus_if.req1_done) begin
               id = bus_if.req1_done ? 1 : 0;
               check("done_exclusive", bus_if.req0_done & bus_if.req1_done, 0);
               check("done_expected", exp_d.size() > 0, 1);
               if (exp_d.size() > 0) begin
                  e = exp_d.pop_front();
                  check("done_id", id, e.id);
                  if (e.dcyc >= 0) check("done_cycle", cyc, e.dcyc);
                  check("done_rdata", id ? bus_if.req1_rdata : bus_if.req0_rdata, e.rdata);
                  check("done_fault", id ? bus_if.req1_fault : bus_if.req0_fault, e.fault);
                  check("done_grant", bus_if.grant, id);
                  check("done_busy", bus_if.busy, 1);
                  check("hold_addr", bus_if.bus_address, last_s.addr);
                  check("hold_rw", bus_if.bus_RW, last_s.rw);
                  m_rdata[e.id] = e.rdata;
                  m_fault[e.id] = e.fault;
               end
               check("other_rdata", id ? bus_if.req0_rdata : bus_if.req1_rdata, m_rdata[1 - id]);
               check("other_fault", id ? bus_if.req0_fault : bus_if.req1_fault, m_fault[1 - id]);
            end
            prev_strobe = bus_if.bus_strobe;
         end
      end
   end

   initial begin : stimulus
      int t;
      bus_if.req0_valid = 1'b0; bus_if.req0_RW = 1'b0; bus_if.req0_address = '0; bus_if.req0_wdata = '0;
      bus_if.req1_valid = 1'b0; bus_if.req1_RW = 1'b0; bus_if.req1_address = '0; bus_if.req1_wdata = '0;
      bus_if.bus_ack = 1'b0; bus_if.bus_error = 1'b0; bus_if.bus_data_in = '0;

      repeat (3) @(negedge clk);
      check("rst_done0", bus_if.req0_done, 0);
      check("rst_done1", bus_if.req1_done, 0);
      check("rst_rdata0", bus_if.req0_rdata, 0);
      check("rst_rdata1", bus_if.req1_rdata, 0);
      check("rst_faults", {bus_if.req0_fault, bus_if.req1_fault}, 0);
      check("rst_strobe", bus_if.bus_strobe, 0);
      check("rst_bus", {bus_if.bus_RW, bus_if.bus_address, bus_if.bus_data_out[22:0]}, 0);
      check("rst_busy_grant", {bus_if.busy, bus_if.grant}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Contention twice: req0 first each time, then req1 four cycles later.
      for (int r = 0; r < 2; r++) begin
         t = cyc;
         raise(0, 1'b0, 8'h10, 32'h0);
         raise(1, 1'b0, 8'h11, 32'h0);
         expect_strobe(1'b0, 8'h10, 32'h0);
         expect_strobe(1'b0, 8'h11, 32'h0);
         expect_done(0, 32'h1000_0000 + r, 1'b0, t + 3);
         expect_done(1, 32'h1100_0000 + r, 1'b0, t + 7);
         serve(0, 1'b0, 32'h1000_0000 + r);
         serve(0, 1'b0, 32'h1100_0000 + r);
         @(negedge clk);
      end

      // req1 alone twice.
      for (int r = 0; r < 2; r++) begin
         t = cyc;
         raise(1, 1'b0, 8'h12, 32'h0);
         expect_strobe(1'b0, 8'h12, 32'h0);
         expect_done(1, 32'h1200_0000 + r, 1'b0, t + 3);
         serve(0, 1'b0, 32'h1200_0000 + r);
         @(negedge clk);
      end

      // Minimum-latency read.
      t = cyc;
      raise(0, 1'b0, 8'h05, 32'h0);
      expect_strobe(1'b0, 8'h05, 32'h0);
      expect_done(0, 32'hDEAD_BEEF, 1'b0, t + 3);
      serve(0, 1'b0, 32'hDEAD_BEEF);
      @(negedge clk);
      check("read_idle_busy", bus_if.busy, 0);
      check("read_idle_addr", bus_if.bus_address, 8'h05);

      // Write: captured data must be 0 even though the bus drives data.
      t = cyc;
      raise(1, 1'b1, 8'h21, 32'h0000_0064);
      expect_strobe(1'b1, 8'h21, 32'h0000_0064);
      expect_done(1, 32'h0, 1'b0, t + 3);
      serve(0, 1'b0, 32'hFFFF_FFFF);
      @(negedge clk);

      // Timeout: no ack, done 17 cycles after strobe.
      t = cyc;
      raise(0, 1'b0, 8'hFF, 32'h0);
      expect_strobe(1'b0, 8'hFF, 32'h0);
      expect_done(0, 32'h0, 1'b1, t + 18);
      serve(-1, 1'b0, 32'h0);
      @(negedge clk);
      check("timeout_idle_busy", bus_if.busy, 0);

      // Ack on the timeout cycle wins.
      t = cyc;
      raise(1, 1'b0, 8'h40, 32'h0);
      expect_strobe(1'b0, 8'h40, 32'h0);
      expect_done(1, 32'h1234_5678, 1'b0, t + 18);
      serve(15, 1'b0, 32'h1234_5678);
      @(negedge clk);

      // Bus error on a read: data still captured, fault raised.
      t = cyc;
      raise(0, 1'b0, 8'h80, 32'h0);
      expect_strobe(1'b0, 8'h80, 32'h0);
      expect_done(0, 32'hCAFE_F00D, 1'b1, t + 3);
      serve(0, 1'b1, 32'hCAFE_F00D);
      @(negedge clk);
      check("error_idle_busy", bus_if.busy, 0);

      // Reset in WAIT_ACK, then the still-valid request is served afresh.
      raise(0, 1'b0, 8'h33, 32'h0);
      expect_strobe(1'b0, 8'h33, 32'h0);
      expect_strobe(1'b0, 8'h33, 32'h0);
      wait_strobe();
      @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("mid_rst_busy", bus_if.busy, 0);
      check("mid_rst_strobe_done", {bus_if.bus_strobe, bus_if.req0_done, bus_if.req1_done}, 0);
      check("mid_rst_addr", bus_if.bus_address, 0);
      check("mid_rst_rdata0", bus_if.req0_rdata, 0);
      check("mid_rst_rdata1", bus_if.req1_rdata, 0);
      check("mid_rst_fault0", bus_if.req0_fault, 0);
      @(negedge clk);
      #2 reset = 1'b0;
      t = cyc;
      expect_done(0, 32'h0BAD_F00D, 1'b0, t + 3);
      serve(0, 1'b0, 32'h0BAD_F00D);

      repeat (6) @(negedge clk);
      check("strobe_queue_empty", exp_s.size(), 0);
      check("done_queue_empty", exp_d.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
      $fatal(1);
   end
endmodule
